// File: rtl/svc_uart_rx_buf_if.sv
// Byte-stream handshake between the UART receive buffer and its consumer.
interface svc_uart_rx_buf_if;
  logic       urx_valid;
  logic [7:0] urx_data;
  logic       urx_ready;

  modport master (output urx_valid, output urx_data, input  urx_ready);
  modport slave  (input  urx_valid, input  urx_data, output urx_ready);
endinterface

// File: rtl/svc_uart_rx_buf.sv
// 8N1 UART receiver with mid-bit sampling feeding a first-word fall-through FIFO.
module svc_uart_rx_buf #(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               urx,
  svc_uart_rx_buf_if.master  rx_if,
  output logic               frame_err,
  output logic               overflow
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   CNT_MAX  = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q, overflow_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];

  logic rx_s;
  logic push, pop, push_ok;

  assign rx_s = sync2_q;

  // Framing FSM: cnt counts down in every timed state; a zero marks a sample point.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = CNT_HALF;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          if (!rx_s) begin
            state_d   = ST_DATA;
            cnt_d     = CNT_FULL;
            bit_idx_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shreg_d   = {rx_s, shreg_q[7:1]};
          cnt_d     = CNT_FULL;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pop frees a slot in the same cycle, so a push into a full FIFO is still accepted.
  always_comb begin
    pop        = (count_q != '0) && rx_if.urx_ready;
    push_ok    = push && ((count_q != CNT_MAX) || pop);
    overflow_d = push && !push_ok;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shreg_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop) count_d = count_q + (PTR_W+1)'(1);
    else if (pop && !push_ok) count_d = count_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= urx;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: it is only visible through a non-zero count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rx_if.urx_valid = (count_q != '0);
  assign rx_if.urx_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign frame_err       = frame_err_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_svc_uart_rx_buf.sv
// Self-checking bench for svc_uart_rx_buf: vector table, corner sequences, randomized frames.
module tb_svc_uart_rx_buf;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic urx = 1'b1;
  logic frame_err, overflow;

  svc_uart_rx_buf_if bus ();

  svc_uart_rx_buf #(
    .CLOCK_FREQ(16),
    .BAUD_RATE (1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .urx      (urx),
    .rx_if    (bus),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: monotonic logs and totals, sampled on the falling edge.
  logic [7:0]  rx_log[$];
  int unsigned pop_cyc_log[$];
  int          ferr_tot = 0, ovf_tot = 0, valid_hi_tot = 0, bad_tot = 0;
  int unsigned rise_cyc = 0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.urx_valid && bus.urx_ready) begin
        rx_log.push_back(bus.urx_data);
        pop_cyc_log.push_back(cyc);
      end
      if (frame_err) ferr_tot <= ferr_tot + 1;
      if (overflow) ovf_tot <= ovf_tot + 1;
      if (bus.urx_valid) valid_hi_tot <= valid_hi_tot + 1;
      if (bus.urx_valid && !prev_valid) rise_cyc <= cyc;
      if ((!bus.urx_valid && bus.urx_data != 8'h00) || (frame_err && overflow))
        bad_tot <= bad_tot + 1;
    end
    prev_valid <= rst_n && bus.urx_valid;
  end

  int checks = 0;
  int failures = 0;
  int b_rx, b_ferr, b_ovf, b_vhi;
  int unsigned start_cyc;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mark();
    b_rx   = rx_log.size();
    b_ferr = ferr_tot;
    b_ovf  = ovf_tot;
    b_vhi  = valid_hi_tot;
  endtask

  function automatic int n_rx();
    return rx_log.size() - b_rx;
  endfunction

  function automatic int rx_at(input int i);
    if (b_rx + i < rx_log.size()) return int'(rx_log[b_rx + i]);
    return -1;
  endfunction

  // Drives one 8N1 character starting now; a low stop bit is followed by a 64-cycle break.
  task automatic send(input logic [7:0] b, input logic stop, input int gap);
    urx = 1'b0;
    start_cyc = cyc;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      urx = b[i];
      tick(CPB);
    end
    urx = stop;
    tick(CPB);
    if (!stop) begin
      tick(64);
      urx = 1'b1;
      tick(CPB);
    end
    urx = 1'b1;
    tick(gap);
  endtask

  task automatic drain();
    bus.urx_ready = 1'b1;
    tick(12);
    bus.urx_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_push;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] exp_q[$];
    int exp_ferr, n, lat;
    logic [7:0] b;
    logic s;

    vecs[0] = '{8'h3C, 1'b0, 0, 1};
    vecs[1] = '{8'h5A, 1'b1, 1, 0};
    vecs[2] = '{8'h00, 1'b1, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1, 0};
    vecs[4] = '{8'h00, 1'b0, 0, 1};
    vecs[5] = '{8'h80, 1'b1, 1, 0};
    vecs[6] = '{8'h7E, 1'b0, 0, 1};
    vecs[7] = '{8'h01, 1'b1, 1, 0};

    bus.urx_ready = 1'b0;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Idle line after reset
    mark();
    bus.urx_ready = 1'b1;
    tick(100);
    chk("idle_valid", int'(bus.urx_valid), 0);
    chk("idle_data", int'(bus.urx_data), 0);
    chk("idle_pops", n_rx(), 0);
    chk("idle_ferr", ferr_tot - b_ferr, 0);
    chk("idle_ovf", ovf_tot - b_ovf, 0);

    // Single 0xA5 with ready high
    mark();
    send(8'hA5, 1'b1, 40);
    lat = int'(rise_cyc - start_cyc);
    chk("a5_count", n_rx(), 1);
    chk("a5_data", rx_at(0), 8'hA5);
    chk("a5_valid_cycles", valid_hi_tot - b_vhi, 1);
    chk("a5_latency_in_153_155", int'(lat >= 153 && lat <= 155), 1);

    // Vector table
    foreach (vecs[i]) begin
      mark();
      send(vecs[i].data, vecs[i].stop, 20);
      chk($sformatf("vec%0d_count", i), n_rx(), vecs[i].exp_push);
      if (vecs[i].exp_push != 0) chk($sformatf("vec%0d_data", i), rx_at(0), int'(vecs[i].data));
      chk($sformatf("vec%0d_ferr", i), ferr_tot - b_ferr, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_ovf", i), ovf_tot - b_ovf, 0);
    end

    // Short glitch is rejected, then 0xFF
    mark();
    urx = 1'b0;
    tick(4);
    urx = 1'b1;
    tick(40);
    chk("glitch_count", n_rx(), 0);
    chk("glitch_ferr", ferr_tot - b_ferr, 0);
    chk("glitch_ovf", ovf_tot - b_ovf, 0);
    send(8'hFF, 1'b1, 20);
    chk("post_glitch_count", n_rx(), 1);
    chk("post_glitch_data", rx_at(0), 8'hFF);

    // Overflow on the fifth back-to-back byte
    mark();
    bus.urx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 0);
    tick(4);
    chk("ovf_before_fifth", ovf_tot - b_ovf, 0);
    send(8'h05, 1'b1, 20);
    chk("ovf_after_fifth", ovf_tot - b_ovf, 1);
    drain();
    chk("ovf_drain_count", n_rx(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("ovf_drain_data%0d", i), rx_at(i), i + 1);
    if (n_rx() == 4)
      chk("ovf_drain_consecutive",
          int'(pop_cyc_log[b_rx + 3] - pop_cyc_log[b_rx]), 3);
    chk("ovf_drain_valid", int'(bus.urx_valid), 0);

    // Ready raised exactly in the push cycle of a full FIFO
    mark();
    for (int i = 1; i <= 4; i++) send(8'(i * 17), 1'b1, 0);
    fork
      send(8'h55, 1'b1, 20);
      begin
        tick(154);
        bus.urx_ready = 1'b1;
        tick(1);
        bus.urx_ready = 1'b0;
      end
    join
    chk("simul_ovf", ovf_tot - b_ovf, 0);
    chk("simul_one_pop", n_rx(), 1);
    chk("simul_still_valid", int'(bus.urx_valid), 1);
    drain();
    chk("simul_total", n_rx(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("simul_data%0d", i), rx_at(i), (i + 1) * 17);

    // Randomized frames, ready high: good bytes arrive in order, bad ones count as frame errors
    mark();
    exp_q.delete();
    exp_ferr = 0;
    bus.urx_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      s = ($urandom_range(0, 9) != 0);
      if (s) exp_q.push_back(b);
      else exp_ferr++;
      send(b, s, int'($urandom_range(0, 20)));
    end
    tick(40);
    bus.urx_ready = 1'b0;
    chk("rand_count", n_rx(), exp_q.size());
    foreach (exp_q[i]) chk($sformatf("rand_data%0d", i), rx_at(i), int'(exp_q[i]));
    chk("rand_ferr", ferr_tot - b_ferr, exp_ferr);
    chk("rand_ovf", ovf_tot - b_ovf, 0);

    // Randomized burst with ready low: capacity-4 queue model
    mark();
    exp_q.delete();
    n = int'($urandom_range(1, 7));
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (exp_q.size() < 4) exp_q.push_back(b);
      send(b, 1'b1, int'($urandom_range(0, 10)));
    end
    tick(20);
    chk("burst_ovf", ovf_tot - b_ovf, (n > 4) ? n - 4 : 0);
    drain();
    chk("burst_count", n_rx(), exp_q.size());
    foreach (exp_q[i]) chk($sformatf("burst_data%0d", i), rx_at(i), int'(exp_q[i]));

    // Reset mid-DATA with two bytes queued
    send(8'h21, 1'b1, 5);
    send(8'h22, 1'b1, 5);
    chk("rst_pre_valid", int'(bus.urx_valid), 1);
    fork
      send(8'hF0, 1'b1, 20);
      begin
        tick(104);
        rst_n = 1'b0;
        tick(1);
        chk("rst_valid", int'(bus.urx_valid), 0);
        chk("rst_data", int'(bus.urx_data), 0);
        rst_n = 1'b1;
      end
    join
    mark();
    bus.urx_ready = 1'b1;
    send(8'h81, 1'b1, 30);
    bus.urx_ready = 1'b0;
    chk("post_rst_count", n_rx(), 1);
    chk("post_rst_data", rx_at(0), 8'h81);
    chk("post_rst_ferr", ferr_tot - b_ferr, 0);

    chk("invariants", bad_tot, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/svc_uart_rx_buf.md
# svc_uart_rx_buf

Buffered UART receiver that turns a raw asynchronous serial line into a valid/ready byte stream. It sits directly upstream of the SoC debug-UART receive port (`dbg_urx_valid` / `dbg_urx_data` / `dbg_urx_ready`), which is currently tied off in the board tops. It synchronizes the line, frames 8N1 characters by mid-bit sampling, and queues received bytes in a small FIFO so the consumer may stall without losing data.

## Interface

Parameters:
- `CLOCK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 115_200: line rate. `CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE` (integer division, truncating). It must be ≥ 4.
- `FIFO_DEPTH`, 8: byte entries. Must be a power of 2, ≥ 2.

Ports:
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `urx`, input, 1: asynchronous serial line; idles high.
- `urx_valid`, output, 1: FIFO non-empty.
- `urx_data`, output, 8: head byte. Reads 8'h00 whenever `urx_valid` = 0.
- `urx_ready`, input, 1: consumer accepts the head byte.
- `frame_err`, output, 1: one-cycle pulse when a stop bit is sampled low.
- `overflow`, output, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation

- Synchronizer: 2-flop chain on `urx`, reset to 1. All framing logic uses the second flop, `rx_s`.
- Bit counter `cnt`: reload-and-decrement. A sample is taken in the cycle where `cnt == 0`.
- FSM states:
  - IDLE: when `rx_s == 0`, go to START and load `cnt = CLKS_PER_BIT/2 - 1`.
  - START: at `cnt == 0`:
    - If `rx_s == 0`, go to DATA, load `cnt = CLKS_PER_BIT - 1`, set `bit_idx = 0`.
    - Otherwise the start was a glitch: return to IDLE with no output.
  - DATA: at each `cnt == 0`, shift `rx_s` into `shreg` LSB-first and reload `cnt = CLKS_PER_BIT - 1`. After `bit_idx == 7` is sampled, go to STOP.
  - STOP: at `cnt == 0`:
    - If `rx_s == 1`, push `shreg` and go to IDLE.
    - If `rx_s == 0`, pulse `frame_err`, discard the byte, and go to BREAK.
  - BREAK: wait for `rx_s == 1`, then go to IDLE. A held-low line therefore produces exactly one `frame_err`, not repeated framing.
- FIFO behaviour:
  - Circular buffer with read/write pointers plus a count of width `$clog2(FIFO_DEPTH)+1`; pointers wrap modulo `FIFO_DEPTH`.
  - First-word fall-through: `urx_data` is the entry at the read pointer.
  - Pop occurs when `urx_valid && urx_ready`.
  - A push is accepted if `count < FIFO_DEPTH`, or if a pop occurs in the same cycle. Simultaneous push+pop leaves count unchanged.
  - A push with a full FIFO and no pop is dropped and pulses `overflow`. FIFO contents are unchanged.
  - Push and pop on an empty FIFO cannot coincide, because pop requires `urx_valid`.
- `urx_ready` has no effect while `urx_valid` = 0.
- `frame_err` and `overflow` never assert in the same cycle; only one push or frame decision occurs per character.

## Timing

- Reset values:
  - FSM in IDLE; `cnt`, `bit_idx`, `shreg` = 0.
  - FIFO empty; sync flops = 1.
  - `urx_valid` = 0, `urx_data` = 8'h00, `frame_err` = 0, `overflow` = 0.
- Reset mid-character or with the FIFO non-empty discards everything. The first cycle after reset release behaves as IDLE.
- Input latency: 2 cycles from `urx` to `rx_s`. Sample points are CLKS_PER_BIT/2 after the start edge, then every CLKS_PER_BIT.
- Push is registered: `urx_valid` rises, and `urx_data` is valid, in the cycle after the stop-bit sample.
- Pop is registered: the next head (or 8'h00 / `urx_valid` = 0) appears in the cycle after the `valid && ready` cycle.
- Back-to-back characters: STOP returns to IDLE on the sample cycle, so a start bit arriving from the half-stop point onward is caught.
- `frame_err` and `overflow` are each high for exactly the cycle after the stop sample.

## Test plan

Use `CLOCK_FREQ=16`, `BAUD_RATE=1` (CLKS_PER_BIT = 16) and `FIFO_DEPTH=4` unless noted.

- Reset, then drive `urx=1` for 100 cycles -> `urx_valid`=0, `urx_data`=8'h00, no pulses.
- Send 0xA5 (8N1) with `urx_ready`=1 -> `urx_valid` high for exactly 1 cycle with `urx_data`=8'hA5, one cycle after the stop sample (2+8+8·16+16 cycles after the start edge, ±1).
- Hold `urx_ready`=0 and send 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back:
  - `overflow` pulses once, on the fifth byte.
  - Raising ready then yields 01, 02, 03, 04 on consecutive cycles, after which `urx_valid`=0.
- Send 0x3C with the stop bit driven low, then hold low 64 cycles, then high -> exactly one `frame_err` pulse, no push. A following 0x5A is received correctly.
- Drive a 4-cycle low glitch on an idle line -> START rejects it, no push and no pulses. A subsequent 0xFF is received intact.
- With the FIFO full (ready=0), raise `urx_ready` exactly on the cycle of a new push -> no `overflow`; count stays 4; the new byte appears last in order.
- Assert `rst_n`=0 mid-DATA with 2 bytes queued -> next cycle `urx_valid`=0; a fresh 0x81 after release is received correctly.
